// File: rtl/bcd12_bin_if.sv
// Start/done handshake bundle for the 3-digit BCD to 10-bit binary converter.
// The master supplies start/bcd; the converter (slave) returns busy/done/err/bin.
interface bcd12_bin_if;
   logic        start;
   logic [11:0] bcd;
   logic        busy;
   logic        done;
   logic        err;
   logic [9:0]  bin;

   modport master (output start, output bcd, input busy, input done, input err, input bin);
   modport slave  (input start, input bcd, output busy, output done, output err, output bin);
endinterface

// File: rtl/bcd12_bin.sv
// Iterative reverse double-dabble: converts packed 3-digit BCD to binary, one bit per clock.
// Digits above 9 are rejected immediately with err and a single done pulse.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// CONV  | shifting x right once per cycle, cnt counts iterations 0..9; busy=1
module bcd12_bin (
   input  logic       clk,
   input  logic       rst,
   bcd12_bin_if.slave bus
);
   typedef enum logic {IDLE, CONV} state_t;

   state_t      state;
   logic [21:0] x;
   logic [21:0] y_shift;
   logic [21:0] y;
   logic [3:0]  cnt;
   logic        bad_digit;

   function automatic logic [3:0] adj(input logic [3:0] n);
      return (n >= 4'd8) ? n - 4'd3 : n;
   endfunction

   // x[21:10] is the BCD field draining into the binary field x[9:0]
   assign y_shift   = {1'b0, x[21:1]};
   assign y         = {adj(y_shift[21:18]), adj(y_shift[17:14]), adj(y_shift[13:10]), y_shift[9:0]};
   assign bad_digit = (bus.bcd[11:8] > 4'd9) | (bus.bcd[7:4] > 4'd9) | (bus.bcd[3:0] > 4'd9);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         x        <= '0;
         cnt      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         bus.bin  <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bad_digit) begin
                     bus.err  <= 1'b1;
                     bus.bin  <= '0;
                     bus.done <= 1'b1;
                  end else begin
                     x        <= {bus.bcd, 10'b0};
                     bus.err  <= 1'b0;
                     cnt      <= '0;
                     bus.busy <= 1'b1;
                     state    <= CONV;
                  end
               end
            end
            CONV: begin
               x <= y;
               if (cnt == 4'd9) begin
                  cnt      <= '0;
                  bus.bin  <= y[9:0];
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
